ps2_frame_receiver: RTL

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver.
// Synchronizes and glitch-filters the PS/2 clock and samples data on filtered falling
// edges. It decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// reports each frame with a single-cycle result pulse.
//
// Parameters:
//   FILTER_LEN     - consecutive identical ps2_clk samples needed to accept a level change
//   TIMEOUT_CYCLES - global_clk cycles without a sample strobe that abort a frame
// Ports:
//   global_clk   - system clock, rising edge
//   global_rst_n - asynchronous active-low reset
//   ps2_clk      - raw PS/2 clock line (asynchronous)
//   ps2_data     - raw PS/2 data line (asynchronous)
//   scan_code    - last correctly received byte, held until the next good frame
//   scan_valid   - one-cycle pulse marking a new scan_code
//   parity_err   - one-cycle pulse for a frame rejected on odd parity
//   frame_err    - one-cycle pulse for a bad stop bit or a timeout
module ps2_frame_receiver #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic       global_clk,
   input  logic       global_rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic          filt_clk_q;
   logic [FW-1:0] filt_cnt_q;
   logic          filt_done;
   logic          strobe;

   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;

   // Synchronizers and clock filter; both lines idle high.
   always_ff @(posedge global_clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         filt_clk_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         data_s1_q <= ps2_data;
         data_s2_q <= data_s1_q;
         if (clk_s2_q != filt_clk_q) begin
            if (filt_done) begin
               filt_clk_q <= clk_s2_q;
               filt_cnt_q <= '0;
            end else begin
               filt_cnt_q <= filt_cnt_q + 1'b1;
            end
         end else begin
            filt_cnt_q <= '0;
         end
      end
   end

   assign filt_done = (filt_cnt_q == FW'(FILTER_LEN - 1));
   // Strobe in the same cycle the filtered clock commits to 0.
   assign strobe    = filt_clk_q && !clk_s2_q && filt_done;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;

      if (state_q == StIdle || strobe) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
      tmo_hit = (state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

      // Timeout wins over a coincident strobe, which is then dropped.
      if (tmo_hit) begin
         state_d   = StIdle;
         tmo_d     = '0;
         bit_cnt_d = '0;
         shift_d   = '0;
         ferr_d    = 1'b1;
      end else if (strobe) begin
         case (state_q)
            StIdle: begin
               if (!data_s2_q) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            StData: begin
               shift_d   = {data_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               par_d   = data_s2_q;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (!data_s2_q) begin
                  ferr_d = 1'b1;
               end else if (^{shift_q, par_q}) begin
                  valid_d = 1'b1;
                  code_d  = shift_q;
               end else begin
                  perr_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge global_clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign scan_code  = code_q;
   assign scan_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule
